// File: rtl/player_r2r_fetch.sv
// player_r2r_fetch: AXI4-Lite read initiator that streams packed 8-bit samples
// from memory into a small word FIFO and plays them out to an R2R DAC, one
// sample per prescaler tick, four little-endian samples per fetched word.
// Optional build macro: PLAYER_R2R_LOOP_EN (continuous looped playback).
module player_r2r_fetch #(
  parameter int PRESC_MAX = 2267,
  parameter int FIFO_AW   = 3
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_words,
  output logic [31:0] M_ARADDR,
  output logic [2:0]  M_ARPROT,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  output logic [7:0]  DAC,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  underrun_cnt
);

  localparam int PW    = $clog2(PRESC_MAX + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  // S_WAIT parks the fetcher between words until the FIFO has room;
  // S_STOP_A / S_STOP_R finish the address and data phases after a stop.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WAIT, S_DRAIN, S_STOP_A, S_STOP_R
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]      presc;
  logic               tick;
  logic               play;

  logic [31:0]        addr;
  logic [15:0]        words_left;

  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_empty, fifo_full;

  logic [31:0]        cur_word;
  logic [1:0]         byte_idx;
  logic               cur_valid;

  logic               start_idle, launch, push, pop, flush;
  logic               fin_done, err_set, advance, reload;
  logic               ar_valid, r_ready;

  assign tick       = (presc == PW'(PRESC_MAX));
  assign busy       = (state != S_IDLE);
  assign play       = tick && busy;
  assign start_idle = (state == S_IDLE) && start;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));

  assign M_ARADDR   = addr;
  assign M_ARPROT   = 3'b000;
  assign M_ARVALID  = ar_valid;
  assign M_RREADY   = r_ready;

  // Unpacker takes a new word whenever it is empty, or right after playing
  // its last byte on a tick; a flush overrides both.
  assign pop = !flush && !fifo_empty &&
               (!cur_valid || (play && cur_valid && (byte_idx == 2'd3)));

  // Free-running sample-rate prescaler; start never restarts it.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || tick) presc <= '0;
    else                  presc <= presc + 1'b1;
  end

  // Fetch FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_next;
  end

  // Fetch FSM next-state and handshake/control decode.
  always_comb begin
    state_next = state;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    launch     = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    fin_done   = 1'b0;
    err_set    = 1'b0;
    advance    = 1'b0;
    reload     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words != 16'd0) begin
            launch     = 1'b1;
            state_next = S_ADDR;
          end else begin
            fin_done = 1'b1;
          end
        end
      end
      S_ADDR: begin
        ar_valid = 1'b1;
        if (stop)           state_next = M_ARREADY ? S_STOP_R : S_STOP_A;
        else if (M_ARREADY) state_next = S_DATA;
      end
      S_DATA: begin
        r_ready = 1'b1;
        if (M_RVALID) begin
          if (M_RRESP != 2'b00) begin
            err_set    = 1'b1;
            flush      = 1'b1;
            state_next = S_IDLE;
          end else if (stop) begin
            flush      = 1'b1;
            state_next = S_IDLE;
          end else begin
            push    = 1'b1;
            advance = 1'b1;
            if (words_left == 16'd1) begin
`ifdef PLAYER_R2R_LOOP_EN
              reload     = 1'b1;
              state_next = S_WAIT;
`else
              state_next = S_DRAIN;
`endif
            end else begin
              state_next = S_WAIT;
            end
          end
        end else if (stop) begin
          state_next = S_STOP_R;
        end
      end
      S_WAIT: begin
        if (stop) begin
          flush      = 1'b1;
          state_next = S_IDLE;
        end else if (!fifo_full) begin
          state_next = S_ADDR;
        end
      end
      S_DRAIN: begin
        if (stop) begin
          flush      = 1'b1;
          state_next = S_IDLE;
        end else if (fifo_empty && !cur_valid) begin
          fin_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_STOP_A: begin
        ar_valid = 1'b1;
        if (M_ARREADY) state_next = S_STOP_R;
      end
      S_STOP_R: begin
        r_ready = 1'b1;
        if (M_RVALID) begin
          err_set    = (M_RRESP != 2'b00);
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef PLAYER_R2R_LOOP_EN
  logic [31:0] base_lat;
  logic [15:0] num_lat;

  // Read address and remaining-word counter, reloaded at the end of each pass.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr       <= '0;
      words_left <= '0;
      base_lat   <= '0;
      num_lat    <= '0;
    end else if (launch) begin
      addr       <= base_addr & ~32'h3;
      base_lat   <= base_addr & ~32'h3;
      words_left <= num_words;
      num_lat    <= num_words;
    end else if (advance) begin
      if (reload) begin
        addr       <= base_lat;
        words_left <= num_lat;
      end else begin
        addr       <= addr + 32'd4;
        words_left <= words_left - 16'd1;
      end
    end
  end
`else
  // Read address and remaining-word counter for single-shot playback.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr       <= '0;
      words_left <= '0;
    end else if (launch) begin
      addr       <= base_addr & ~32'h3;
      words_left <= num_words;
    end else if (advance && !reload) begin
      addr       <= addr + 32'd4;
      words_left <= words_left - 16'd1;
    end
  end
`endif

  // Word FIFO storage; pushes only happen when there is room.
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr] <= M_RDATA;
  end

  // Word FIFO pointers and occupancy, with simultaneous push/pop honoured.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Unpacker: plays one byte per tick, low byte first, then loads the next word.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      DAC       <= 8'h80;
      cur_word  <= '0;
      byte_idx  <= '0;
      cur_valid <= 1'b0;
    end else if (flush) begin
      byte_idx  <= '0;
      cur_valid <= 1'b0;
    end else begin
      if (play && cur_valid) begin
        DAC      <= cur_word[{byte_idx, 3'b000} +: 8];
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) cur_valid <= 1'b0;
      end
      if (pop) begin
        cur_word  <= fifo_mem[rd_ptr];
        byte_idx  <= '0;
        cur_valid <= 1'b1;
      end
    end
  end

  // Status: completion pulse, sticky bus error, saturating starvation counter.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      done         <= 1'b0;
      error        <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      done <= fin_done;
      if (start_idle)   error <= 1'b0;
      else if (err_set) error <= 1'b1;
      if (start_idle)
        underrun_cnt <= '0;
      else if (play && !cur_valid && (underrun_cnt != 8'hFF))
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_player_r2r_fetch.sv
// tb_player_r2r_fetch: scoreboard bench for player_r2r_fetch with a small
// AXI4-Lite read slave. Expected AR addresses, DAC samples and end-of-playback
// status are queued by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_player_r2r_fetch;

  localparam int PRESC = 63;

  typedef struct {
    bit         exp_done;
    bit         exp_err;
    int         min_under;
    bit         chk_dac;
    logic [7:0] dac;
  } end_exp_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic [31:0] M_ARADDR;
  logic [2:0]  M_ARPROT;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RVALID;
  logic        M_RREADY;
  logic [7:0]  DAC;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  underrun_cnt;

  // slave configuration, written by stimulus only
  int          ar_wait = 1;
  int          r_wait = 1;
  int          slow_word = -1;
  int          slow_extra = 0;
  int          err_word = -1;
  logic [31:0] tb_base = 32'h1000;
  logic [31:0] mem [16];
  bit          loop_mode = 1'b0;
  logic [31:0] loop_addr = '0;

  // scoreboard queues
  logic [31:0] ar_q [$];
  logic [7:0]  dac_q [$];
  end_exp_t    end_q [$];

  // counters stepped by the monitor
  int checks = 0;
  int passes = 0;
  int end_cnt = 0;
  int timeouts_seen = 0;
  // stepped by stimulus when a bounded wait expires
  int timeout_reqs = 0;

  player_r2r_fetch #(.PRESC_MAX(PRESC), .FIFO_AW(3)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop),
    .base_addr(base_addr), .num_words(num_words),
    .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .DAC(DAC), .busy(busy),
    .done(done), .error(error), .underrun_cnt(underrun_cnt)
  );

  always #5 ACLK = ~ACLK;

  // AXI4-Lite read slave: one transaction at a time, programmable latencies
  initial begin
    int widx;
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    M_RDATA   = '0;
    M_RRESP   = 2'b00;
    forever begin
      @(posedge ACLK); #1;
      if (ARESETN && M_ARVALID) begin
        repeat (ar_wait) begin @(posedge ACLK); #1; end
        M_ARREADY = 1'b1;
        widx = int'((M_ARADDR - tb_base) >> 2);
        @(posedge ACLK); #1;
        M_ARREADY = 1'b0;
        repeat (r_wait + ((widx == slow_word) ? slow_extra : 0)) begin
          @(posedge ACLK); #1;
        end
        M_RDATA  = mem[widx & 15];
        M_RRESP  = (widx == err_word) ? 2'b10 : 2'b00;
        M_RVALID = 1'b1;
        @(posedge ACLK); #1;
        M_RVALID = 1'b0;
        M_RRESP  = 2'b00;
      end
    end
  end

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endfunction

  // monitor: compares every DUT presentation against the scoreboard queues
  logic [7:0]  dac_prev = 8'h80;
  logic        busy_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic        arw_prev = 1'b0;
  logic [31:0] araddr_prev = '0;
  bit          rst_checked = 1'b0;

  always @(negedge ACLK) begin
    end_exp_t e;
    if (!ARESETN) begin
      if (!rst_prev && !rst_checked) begin
        checks++;
        if (M_ARVALID === 1'b0 && M_RREADY === 1'b0 && M_ARADDR === 32'h0 &&
            DAC === 8'h80 && busy === 1'b0 && done === 1'b0 && error === 1'b0 &&
            underrun_cnt === 8'h00 && M_ARPROT === 3'b000)
          passes++;
        else
          $display("[TB] FAIL reset_state actual arv=%b rr=%b addr=%h dac=%h busy=%b done=%b err=%b und=%0d required 0 0 0 80 0 0 0 0",
                   M_ARVALID, M_RREADY, M_ARADDR, DAC, busy, done, error, underrun_cnt);
        rst_checked = 1'b1;
      end
      dac_prev  = DAC;
      busy_prev = busy;
      arw_prev  = 1'b0;
    end else begin
      rst_checked = 1'b0;
      if (M_ARVALID && M_ARREADY) begin
        if (loop_mode) cmp("ar_addr_loop", M_ARADDR, loop_addr);
        else if (ar_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL ar_unexpected actual=%h required=no transaction", M_ARADDR);
        end else cmp("ar_addr", M_ARADDR, ar_q.pop_front());
      end
      if (arw_prev) begin
        checks++;
        if (M_ARVALID === 1'b1 && M_ARADDR === araddr_prev) passes++;
        else $display("[TB] FAIL ar_stable actual arv=%b addr=%h required arv=1 addr=%h",
                      M_ARVALID, M_ARADDR, araddr_prev);
      end
      arw_prev    = M_ARVALID && !M_ARREADY;
      araddr_prev = M_ARADDR;

      if (DAC !== dac_prev) begin
        if (dac_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL dac_unexpected actual=%h required=hold %h", DAC, dac_prev);
        end else cmp("dac_sample", {24'h0, DAC}, {24'h0, dac_q.pop_front()});
        dac_prev = DAC;
      end

      if ((busy_prev && !busy) || (done && !busy_prev)) begin
        end_cnt++;
        if (end_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL end_unexpected actual=busy %b done %b required=no end event", busy, done);
        end else begin
          e = end_q.pop_front();
          cmp("done_pulse", {31'h0, done}, {31'h0, e.exp_done});
          cmp("error_flag", {31'h0, error}, {31'h0, e.exp_err});
          if (e.min_under > 0) begin
            checks++;
            if (int'(underrun_cnt) >= e.min_under) passes++;
            else $display("[TB] FAIL underrun_cnt actual=%0d required>=%0d", underrun_cnt, e.min_under);
          end
          if (e.chk_dac) cmp("dac_final", {24'h0, DAC}, {24'h0, e.dac});
          cmp("samples_pending", dac_q.size(), 0);
          cmp("ar_pending", ar_q.size(), 0);
        end
      end else if (done) begin
        checks++;
        $display("[TB] FAIL done_spurious actual=1 required=0");
      end
      busy_prev = busy;
    end
    rst_prev = ARESETN;
    if (timeout_reqs != timeouts_seen) begin
      checks++;
      timeouts_seen++;
      $display("[TB] FAIL wait_timeout actual=no event required=event within budget");
    end
  end

  task automatic do_reset();
    ARESETN = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [15:0] n);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input int budget);
    int seen;
    int cyc;
    seen = end_cnt;
    cyc = 0;
    while (end_cnt == seen && cyc < budget) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    if (end_cnt == seen) timeout_reqs++;
  endtask

  task automatic exp_bytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    dac_q.push_back(b0);
    dac_q.push_back(b1);
    dac_q.push_back(b2);
    dac_q.push_back(b3);
  endtask

  task automatic exp_end(input bit d, input bit er, input int mu, input bit cd, input logic [7:0] dv);
    end_exp_t e;
    e.exp_done = d; e.exp_err = er; e.min_under = mu; e.chk_dac = cd; e.dac = dv;
    end_q.push_back(e);
  endtask

  initial begin
    do_reset();

    // two-word single-shot playback
    tb_base = 32'h1000;
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    ar_q.push_back(32'h1000);
    ar_q.push_back(32'h1004);
    exp_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    exp_bytes(8'h05, 8'h06, 8'h07, 8'h08);
    exp_end(1, 0, 0, 1, 8'h08);
    applyStimulus(32'h1000, 16'd2);
    checkOutput(3000);

    // zero-length start: done only, no traffic
    exp_end(1, 0, 0, 1, 8'h08);
    applyStimulus(32'h1000, 16'd0);
    checkOutput(50);

    // slow ARREADY and unaligned base
    do_reset();
    ar_wait = 10;
    tb_base = 32'h2000;
    mem[0] = 32'h14131211;
    mem[1] = 32'h18171615;
    ar_q.push_back(32'h2000);
    ar_q.push_back(32'h2004);
    exp_bytes(8'h11, 8'h12, 8'h13, 8'h14);
    exp_bytes(8'h15, 8'h16, 8'h17, 8'h18);
    exp_end(1, 0, 0, 1, 8'h18);
    applyStimulus(32'h2003, 16'd2);
    checkOutput(3000);

    // word 1 read data delayed long enough to starve the DAC
    do_reset();
    ar_wait = 1;
    tb_base = 32'h1000;
    slow_word = 1;
    slow_extra = 600;
    mem[0] = 32'h24232221;
    mem[1] = 32'h28272625;
    ar_q.push_back(32'h1000);
    ar_q.push_back(32'h1004);
    exp_bytes(8'h21, 8'h22, 8'h23, 8'h24);
    exp_bytes(8'h25, 8'h26, 8'h27, 8'h28);
    exp_end(1, 0, 2, 1, 8'h28);
    applyStimulus(32'h1000, 16'd2);
    checkOutput(5000);
    slow_word = -1;
    slow_extra = 0;

    // SLVERR on word 0, then a clean start clears the error
    do_reset();
    err_word = 0;
    mem[0] = 32'h34333231;
    ar_q.push_back(32'h1000);
    exp_end(0, 1, 0, 1, 8'h80);
    applyStimulus(32'h1000, 16'd3);
    checkOutput(200);
    err_word = -1;
    ar_q.push_back(32'h1000);
    exp_bytes(8'h31, 8'h32, 8'h33, 8'h34);
    exp_end(1, 0, 0, 1, 8'h34);
    applyStimulus(32'h1000, 16'd1);
    checkOutput(2000);

    // stop while the address phase is stalled
    do_reset();
    ar_wait = 20;
    ar_q.push_back(32'h1000);
    exp_end(0, 0, 0, 1, 8'h80);
    applyStimulus(32'h1000, 16'd4);
    repeat (2) @(posedge ACLK);
    #1 stop = 1'b1;
    @(posedge ACLK); #1;
    stop = 1'b0;
    checkOutput(200);
    repeat (50) @(posedge ACLK);
    #1 ar_wait = 1;

`ifdef PLAYER_R2R_LOOP_EN
    // looped one-word buffer, ended by stop
    do_reset();
    begin
      int cyc;
      loop_mode = 1'b1;
      loop_addr = 32'h1000;
      mem[0] = 32'h04030201;
      for (int k = 0; k < 3; k++) exp_bytes(8'h01, 8'h02, 8'h03, 8'h04);
      exp_end(0, 0, 0, 1, 8'h04);
      applyStimulus(32'h1000, 16'd1);
      cyc = 0;
      while (dac_q.size() != 0 && cyc < 3000) begin
        @(posedge ACLK); #1;
        cyc++;
      end
      if (dac_q.size() != 0) timeout_reqs++;
      stop = 1'b1;
      @(posedge ACLK); #1;
      stop = 1'b0;
      checkOutput(200);
      repeat (5) @(posedge ACLK);
      #1 loop_mode = 1'b0;
    end
`endif

    repeat (5) @(posedge ACLK);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
